mult_share_arbiter: RTL and testbench

- Round-robin scheduler that shares one sequential multiplier (start/done controller plus shift-add datapath) among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and sequences the multiplier's start/done protocol.
- Returns each product tagged with the requester ID over a single valid/ready response port.
- Sits between the client blocks and the multiplier top level. It is the only driver of the multiplier's start and operand inputs.

---
 rtl/mult_share_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin front end that time-shares one sequential
// multiplier between NREQ requesters and returns ID-tagged products.
module mult_share_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [2:0]              resp_id,
  output logic [2*WIDTH-1:0]      resp_product,
  output logic                    resp_err,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_product,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_rr_ptr;
  logic [2:0]           r_id;
  logic [7:0]           r_cnt;
  logic                 r_mul_start;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_resp_valid;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 r_err;

  logic                 w_gnt_found;
  logic [2:0]           w_gnt_idx;
  logic [WIDTH-1:0]     w_sel_a;
  logic [WIDTH-1:0]     w_sel_b;
  logic                 w_ack_tmo;

  // Round-robin search: first valid requester after the last grant, wrapping.
  always_comb begin
    int unsigned      idx;
    logic [NREQ-1:0]  vshift;
    idx         = 0;
    vshift      = '0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      vshift = req_valid >> idx;
      if (!w_gnt_found && vshift[0]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = idx[2:0];
      end
    end
  end

  // Operand mux for the granted requester and ack-timeout detection.
  always_comb begin
    w_sel_a   = WIDTH'(req_a >> (32'(w_gnt_idx) * WIDTH));
    w_sel_b   = WIDTH'(req_b >> (32'(w_gnt_idx) * WIDTH));
    w_ack_tmo = (9'(r_cnt) + 9'd1) >= 9'(ACK_TIMEOUT);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_gnt_found) w_next = ISSUE;
      ISSUE:     w_next = WAIT_ACK;
      WAIT_ACK: begin
        if (!mul_done) begin
          w_next = WAIT_DONE;
        end else if (w_ack_tmo) begin
          w_next = RESP;
        end
      end
      WAIT_DONE: if (mul_done) w_next = RESP;
      RESP:      if (resp_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Combinational outputs: one-hot grant in IDLE (held low during reset), busy.
  always_comb begin
    req_ready = '0;
    if (rst_n && (r_state == IDLE) && w_gnt_found) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_gnt_idx;
    end
    busy = (r_state != IDLE);
  end

  // Datapath registers: operand latch, start pulse, timeout counter, response.
  // mul_start is registered so it rises the cycle after ISSUE and stays high
  // for exactly the WAIT_ACK residency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= 3'(NREQ - 1);
      r_id         <= '0;
      r_cnt        <= '0;
      r_mul_start  <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_resp_valid <= 1'b0;
      r_prod       <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_found) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_id     <= w_gnt_idx;
            r_rr_ptr <= w_gnt_idx;
          end
        end
        ISSUE: begin
          r_mul_start <= 1'b1;
          r_cnt       <= '0;
        end
        WAIT_ACK: begin
          r_cnt <= r_cnt + 8'd1;
          if (!mul_done) begin
            r_mul_start <= 1'b0;
          end else if (w_ack_tmo) begin
            r_mul_start  <= 1'b0;
            r_err        <= 1'b1;
            r_prod       <= '0;
            r_resp_valid <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (mul_done) begin
            r_prod       <= mul_product;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_start    = r_mul_start;
  assign mul_a        = r_a;
  assign mul_b        = r_b;
  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_id;
  assign resp_product = r_prod;
  assign resp_err     = r_err;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier, reference round-robin
// model and a response scoreboard.
module tb_mult_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int TMO   = 15;
  localparam int LAT   = 5;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [2:0]            resp_id;
  logic [2*WIDTH-1:0]    resp_product;
  logic                  resp_err;
  logic                  mul_start;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_product;
  logic                  busy;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  logic             mul_dis;

  int n_total = 0;
  int n_bad   = 0;

  // scoreboard and reference state
  int   q_id   [$];
  int   q_prod [$];
  bit   q_err  [$];
  int   glog   [$];
  bit   m_idle;
  int   m_ptr;
  int   s_cnt;
  int   gsel;
  logic [NREQ-1:0] exp_rdy;

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  mult_share_arbiter #(
    .NREQ(NREQ),
    .WIDTH(WIDTH),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id(resp_id),
    .resp_product(resp_product),
    .resp_err(resp_err),
    .mul_start(mul_start),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_done(mul_done),
    .mul_product(mul_product),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int glog_at(input int i);
    if (i < glog.size()) return glog[i];
    return -1;
  endfunction

  // Behavioural multiplier: drops done for LAT+1 cycles after a start; never
  // acknowledges while mul_dis is set.
  logic [3:0]       mm_cnt;
  logic [WIDTH-1:0] mm_a, mm_b;
  logic             mm_bsy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_done    <= 1'b1;
      mul_product <= '0;
      mm_bsy      <= 1'b0;
      mm_cnt      <= '0;
      mm_a        <= '0;
      mm_b        <= '0;
    end else if (!mm_bsy) begin
      if (mul_start && !mul_dis) begin
        mm_bsy   <= 1'b1;
        mul_done <= 1'b0;
        mm_cnt   <= 4'(LAT);
        mm_a     <= mul_a;
        mm_b     <= mul_b;
      end
    end else if (mm_cnt == 0) begin
      mm_bsy      <= 1'b0;
      mul_done    <= 1'b1;
      mul_product <= 16'(mm_a) * 16'(mm_b);
    end else begin
      mm_cnt <= mm_cnt - 4'd1;
    end
  end

  // Monitor: reference grant, busy, scoreboard push on grant / pop on response.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_id.delete();
      q_prod.delete();
      q_err.delete();
      m_idle = 1'b1;
      m_ptr  = NREQ - 1;
      s_cnt  = 0;
    end else begin
      gsel = -1;
      if (m_idle) begin
        for (int k = 1; k <= NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (gsel < 0 && ((req_valid >> idx) & 4'd1) != 0) gsel = idx;
        end
      end
      exp_rdy = (gsel >= 0) ? (4'b0001 << gsel) : 4'b0000;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(!m_idle));
      if (mul_start) s_cnt++;
      if (resp_valid) begin
        if (q_id.size() == 0) begin
          chk("resp_spurious", 32'(resp_valid), 0);
        end else begin
          chk("resp_id", 32'(resp_id), q_id[0]);
          chk("resp_product", 32'(resp_product), q_prod[0]);
          chk("resp_err", 32'(resp_err), 32'(q_err[0]));
          if (resp_ready) begin
            if (q_err[0]) chk("start_len", s_cnt, TMO);
            void'(q_id.pop_front());
            void'(q_prod.pop_front());
            void'(q_err.pop_front());
            m_idle = 1'b1;
          end
        end
      end
      if (gsel >= 0) begin
        q_id.push_back(gsel);
        q_prod.push_back(mul_dis ? 0 : int'(op_a[gsel]) * int'(op_b[gsel]));
        q_err.push_back(mul_dis);
        glog.push_back(gsel);
        m_ptr  = gsel;
        m_idle = 1'b0;
        s_cnt  = 0;
      end
    end
  end

  task automatic wait_grants(input int n);
    for (int i = 0; i < 300 && glog.size() < n; i++) @(posedge clk);
    if (glog.size() < n) chk("grant_wait", glog.size(), n);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && !(m_idle && q_id.size() == 0); i++) @(posedge clk);
    if (!(m_idle && q_id.size() == 0)) chk("idle_wait", q_id.size(), 0);
    #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_mul_start", 32'(mul_start), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_mul_b", 32'(mul_b), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_product", 32'(resp_product), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    mul_dis    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs();
    rst_n = 1'b1;

    // round-robin with all requesters continuously valid
    op_a[0] = 8'd3;   op_b[0] = 8'd5;
    op_a[1] = 8'd4;   op_b[1] = 8'd6;
    op_a[2] = 8'd10;  op_b[2] = 8'd10;
    op_a[3] = 8'd255; op_b[3] = 8'd255;
    req_valid = 4'b1111;
    wait_grants(5);
    req_valid = '0;
    wait_idle();
    for (int i = 0; i < 5; i++) chk("rr_order", glog_at(i), exp_order[i]);

    // single request
    op_a[0] = 8'd7; op_b[0] = 8'd9;
    base = glog.size();
    req_valid = 4'b0001;
    wait_grants(base + 1);
    req_valid = '0;
    op_a[0] = 8'd99;  // operands were latched at grant
    wait_idle();
    chk("single_id", glog_at(base), 0);

    // sparse requests
    op_a[2] = 8'd17; op_b[2] = 8'd3;
    op_a[1] = 8'd200; op_b[1] = 8'd2;
    base = glog.size();
    req_valid = 4'b0100;
    wait_grants(base + 1);
    req_valid = '0;
    wait_idle();
    req_valid = 4'b0010;
    wait_grants(base + 2);
    req_valid = '0;
    wait_idle();
    chk("sparse_a", glog_at(base), 2);
    chk("sparse_b", glog_at(base + 1), 1);

    // backpressure: response held, a competing request must not be granted
    resp_ready = 1'b0;
    op_a[3] = 8'd12; op_b[3] = 8'd13;
    base = glog.size();
    req_valid = 4'b1000;
    wait_grants(base + 1);
    req_valid = 4'b0001;
    for (int i = 0; i < 100 && !resp_valid; i++) @(posedge clk);
    chk("bp_resp_seen", 32'(resp_valid), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_no_grant", glog.size(), base + 1);
    resp_ready = 1'b1;
    wait_grants(base + 2);
    req_valid = '0;
    wait_idle();
    chk("bp_next", glog_at(base + 1), 0);

    // ack timeout: multiplier never drops done
    mul_dis = 1'b1;
    op_a[2] = 8'd5; op_b[2] = 8'd6;
    base = glog.size();
    req_valid = 4'b0100;
    wait_grants(base + 1);
    req_valid = '0;
    wait_idle();
    mul_dis = 1'b0;
    chk("tmo_id", glog_at(base), 2);

    // reset in WAIT_DONE, then order check from the reset pointer
    op_a[2] = 8'd21; op_b[2] = 8'd2;
    base = glog.size();
    req_valid = 4'b0100;
    wait_grants(base + 1);
    req_valid = '0;
    for (int i = 0; i < 50 && !(busy && !mul_start && !mul_done); i++) @(posedge clk);
    chk("reach_wait_done", 32'(busy && !mul_start && !mul_done), 1);
    #2;
    req_valid = 4'b0011;
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = glog.size();
    wait_grants(base + 2);
    req_valid = '0;
    wait_idle();
    chk("post_rst_first", glog_at(base), 0);
    chk("post_rst_second", glog_at(base + 1), 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
